char_motion_ctrl: RTL and testbench
===================================

Name: char_motion_ctrl

Overview:
- Upstream of the frame drawer. Converts keyboard keycodes into the character-motion signals the drawer consumes: charIsMoving, charIsRunning, direction and charMoveFrame.
- Enforces tile-locked movement: once a step starts, the character completes a full TILE_SIZE-pixel tile before it can stop or turn.
- Issues one step pulse per pixel moved, paced by frame ticks derived from VGA_VS.

Parameters:
- TILE_SIZE, 16, pixels per tile step (power of two, 2..64).
- ANIM_DIV, 8, frame ticks per charMoveFrame advance.
- TURN_FRAMES, 4, frame ticks spent turning in place.
- KEY_UP / KEY_DOWN / KEY_LEFT / KEY_RIGHT, 8'h1A / 8'h16 / 8'h04 / 8'h07, direction keycodes.
- KEY_RUN, 8'h2C, run-modifier keycode.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-low reset.
- VGA_VS  in  1  vertical sync, synchronous to Clk.
- in_game  in  1  high while the drawer state is draw_main_game.
- keycode  in  8  primary keycode.
- keycode_aux  in  8  secondary keycode (second key held).
- atBounds  in  1  bounds-checker result for the current direction and position.
- charIsMoving  out  1  high in MOVE (and BUMP when enabled).
- charIsRunning  out  1  run flag, latched at tile start.
- direction  out  2  0 down, 1 up, 2 left, 3 right.
- charMoveFrame  out  2  animation frame, 0..2.
- step_pulse  out  1  one-Clk pulse per pixel moved.
- tile_done  out  1  one-Clk pulse when a tile completes.

Behaviour:
- Reset (Reset==0 at a Clk edge): state=IDLE, direction=0, charMoveFrame=0, charIsMoving=0, charIsRunning=0, step_pulse=0, tile_done=0, px_cnt=0, sub=0, anim_cnt=0, vs_q=1.
- Frame tick: tick = VGA_VS & ~vs_q, with vs_q registered each Clk. One tick per frame. All state advances only on tick cycles.
- Key decode: keycode is checked first, then keycode_aux. The first match against the direction keys gives key_dir and key_valid. run_req = (keycode==KEY_RUN) or (keycode_aux==KEY_RUN).
- When in_game==0: force IDLE and clear every counter and pulse. direction holds its value.
- IDLE (charIsMoving=0, charMoveFrame=0). On tick:
  - if !key_valid: stay in IDLE.
  - else if key_dir != direction: direction<=key_dir, turn_cnt<=0, go to TURN.
  - else if atBounds: stay in IDLE.
  - else: charIsRunning<=run_req, px_cnt<=0, sub<=0, anim_cnt<=0, charMoveFrame<=0, go to MOVE.
- TURN (charMoveFrame=1, charIsMoving=0). Each tick increments turn_cnt. On the tick where turn_cnt==TURN_FRAMES-1, go to IDLE. Releasing the key has no effect.
- MOVE. Each tick:
  - sub<=~sub.
  - step = charIsRunning | sub. Walking therefore moves 1 px per 2 frames; running moves 1 px per frame.
  - On step: step_pulse=1 in the same Clk as the tick, and px_cnt++.
  - anim_cnt++. At ANIM_DIV-1, anim_cnt<=0 and charMoveFrame advances 0→1→2→0.
  - Duration: walking takes 2*TILE_SIZE ticks (32 at defaults); running takes TILE_SIZE ticks (16).
- Tile completion: on the step where px_cnt==TILE_SIZE-1, tile_done=1 and px_cnt<=0. Next action in the same tick:
  - key_valid & key_dir==direction & !atBounds: stay in MOVE, relatch charIsRunning<=run_req, keep the charMoveFrame sequence.
  - otherwise: go to IDLE.
- Mid-tile rules: key release, direction change and atBounds are all ignored. Direction never changes while in MOVE.
- Pulses: step_pulse and tile_done are single-cycle and registered; they are 0 on non-tick cycles.
- Reset during MOVE: immediate return to the reset values. No step_pulse is issued in that cycle.

Optional Feature:
- CHAR_MOTION_BUMP_EN defined: at IDLE with key_valid & key_dir==direction & atBounds, enter BUMP. BUMP matches walking MOVE timing (2*TILE_SIZE ticks, charIsMoving=1, charIsRunning=0, charMoveFrame animates) but issues no step_pulse and no tile_done. It then returns to IDLE.
- Not defined: that case stays in IDLE and BUMP does not exist.

Test Plan:
- Reset low for 2 Clk, then release → all outputs 0, direction=0. With no key, 100 ticks leave state in IDLE.
- direction=0, keycode=8'h16 held, walking → charIsMoving=1 on tick 1. Exactly 16 step_pulses over 32 ticks; tile_done on tick 32; charMoveFrame sequence 0,1,2,0 changing every 8 ticks.
- keycode=8'h07, keycode_aux=8'h2C, direction=0 → TURN for 4 ticks (charMoveFrame=1), direction=3. Then MOVE with charIsRunning=1: 16 step_pulses in 16 ticks.
- Key released at tick 5 of a walking tile → tile still completes: 16 pulses total, then IDLE. Key held with atBounds rising at tile end → IDLE, no further pulses.
- atBounds=1 with the key matching direction → no charIsMoving and no pulses. With CHAR_MOTION_BUMP_EN: charIsMoving=1 for 32 ticks, 0 step_pulses.
- Reset low at tick 10 of MOVE → next Clk all outputs at reset values. in_game=0 mid-tile → IDLE, counters cleared.

Source files
------------

// File: rtl/char_motion_ctrl.sv
// Keycode-to-motion controller: tile-locked stepping paced by VGA_VS frame ticks.
// Optional bump-in-place animation against walls: define CHAR_MOTION_BUMP_EN.
module char_motion_ctrl #(
  parameter int unsigned TILE_SIZE   = 16,
  parameter int unsigned ANIM_DIV    = 8,
  parameter int unsigned TURN_FRAMES = 4,
  parameter logic [7:0]  KEY_UP      = 8'h1A,
  parameter logic [7:0]  KEY_DOWN    = 8'h16,
  parameter logic [7:0]  KEY_LEFT    = 8'h04,
  parameter logic [7:0]  KEY_RIGHT   = 8'h07,
  parameter logic [7:0]  KEY_RUN     = 8'h2C
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       VGA_VS,
  input  logic       in_game,
  input  logic [7:0] keycode,
  input  logic [7:0] keycode_aux,
  input  logic       atBounds,
  output logic       charIsMoving,
  output logic       charIsRunning,
  output logic [1:0] direction,
  output logic [1:0] charMoveFrame,
  output logic       step_pulse,
  output logic       tile_done
);

  localparam int unsigned PXW = $clog2(TILE_SIZE);
  localparam int unsigned AW  = $clog2(ANIM_DIV + 1);
  localparam int unsigned TW  = $clog2(TURN_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    MOVE
`ifdef CHAR_MOTION_BUMP_EN
    , BUMP
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       frame_q, frame_d;
  logic             moving_q, moving_d;
  logic             run_q, run_d;
  logic             step_q, step_d;
  logic             done_q, done_d;
  logic [PXW-1:0]   px_q, px_d;
  logic             sub_q, sub_d;
  logic [AW-1:0]    anim_q, anim_d;
  logic [TW-1:0]    turn_q, turn_d;
  logic             vs_q;

  logic       tick, step, run_req, in_move;
  logic [2:0] key_hit;

  // {valid, dir}; dir encoding 0 down, 1 up, 2 left, 3 right
  function automatic logic [2:0] decode(input logic [7:0] k);
    if (k == KEY_DOWN)       return 3'b100;
    else if (k == KEY_UP)    return 3'b101;
    else if (k == KEY_LEFT)  return 3'b110;
    else if (k == KEY_RIGHT) return 3'b111;
    else                     return 3'b000;
  endfunction

  always_comb begin
    tick    = VGA_VS & ~vs_q;
    run_req = (keycode == KEY_RUN) || (keycode_aux == KEY_RUN);
    key_hit = decode(keycode);
    if (!key_hit[2]) key_hit = decode(keycode_aux);

    state_d = state_q;
    dir_d   = dir_q;
    frame_d = frame_q;
    run_d   = run_q;
    px_d    = px_q;
    sub_d   = sub_q;
    anim_d  = anim_q;
    turn_d  = turn_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    step    = 1'b0;
    in_move = (state_q == MOVE);

    if (!in_game) begin
      state_d = IDLE;
      frame_d = '0;
      px_d    = '0;
      sub_d   = 1'b0;
      anim_d  = '0;
      turn_d  = '0;
    end else if (tick) begin
      case (state_q)
        IDLE: begin
          if (key_hit[2]) begin
            if (key_hit[1:0] != dir_q) begin
              dir_d   = key_hit[1:0];
              turn_d  = '0;
              frame_d = 2'd1;
              state_d = TURN;
            end else if (!atBounds) begin
              run_d   = run_req;
              px_d    = '0;
              sub_d   = 1'b0;
              anim_d  = '0;
              frame_d = '0;
              state_d = MOVE;
            end
`ifdef CHAR_MOTION_BUMP_EN
            else begin
              run_d   = 1'b0;
              px_d    = '0;
              sub_d   = 1'b0;
              anim_d  = '0;
              frame_d = '0;
              state_d = BUMP;
            end
`endif
          end
        end
        TURN: begin
          if (turn_q == TW'(TURN_FRAMES - 1)) begin
            turn_d  = '0;
            frame_d = '0;
            state_d = IDLE;
          end else begin
            turn_d = turn_q + 1'b1;
          end
        end
`ifdef CHAR_MOTION_BUMP_EN
        MOVE, BUMP: begin
`else
        MOVE: begin
`endif
          sub_d = ~sub_q;
          step  = run_q | sub_q;
          if (anim_q == AW'(ANIM_DIV - 1)) begin
            anim_d  = '0;
            frame_d = (frame_q == 2'd2) ? 2'd0 : frame_q + 2'd1;
          end else begin
            anim_d = anim_q + 1'b1;
          end
          // Bump shares the walk cadence but never reports pixels or tiles.
          if (step) begin
            step_d = in_move;
            if (px_q == PXW'(TILE_SIZE - 1)) begin
              px_d   = '0;
              done_d = in_move;
              if (in_move && key_hit[2] && key_hit[1:0] == dir_q && !atBounds) begin
                run_d = run_req;
              end else begin
                frame_d = '0;
                state_d = IDLE;
              end
            end else begin
              px_d = px_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

`ifdef CHAR_MOTION_BUMP_EN
    moving_d = (state_d == MOVE) || (state_d == BUMP);
`else
    moving_d = (state_d == MOVE);
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= IDLE;
      dir_q    <= '0;
      frame_q  <= '0;
      moving_q <= 1'b0;
      run_q    <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
      px_q     <= '0;
      sub_q    <= 1'b0;
      anim_q   <= '0;
      turn_q   <= '0;
      vs_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      frame_q  <= frame_d;
      moving_q <= moving_d;
      run_q    <= run_d;
      step_q   <= step_d;
      done_q   <= done_d;
      px_q     <= px_d;
      sub_q    <= sub_d;
      anim_q   <= anim_d;
      turn_q   <= turn_d;
      vs_q     <= VGA_VS;
    end
  end

  assign charIsMoving  = moving_q;
  assign charIsRunning = run_q;
  assign direction     = dir_q;
  assign charMoveFrame = frame_q;
  assign step_pulse    = step_q;
  assign tile_done     = done_q;

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Scoreboard bench for char_motion_ctrl: expected per-tick outputs are queued, then compared.
module tb_char_motion_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       VGA_VS = 1'b0;
  logic       in_game = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic [7:0] keycode_aux = 8'h00;
  logic       atBounds = 1'b0;
  logic       charIsMoving, charIsRunning, step_pulse, tile_done;
  logic [1:0] direction, charMoveFrame;

  char_motion_ctrl dut (
    .Clk(Clk), .Reset(Reset), .VGA_VS(VGA_VS), .in_game(in_game),
    .keycode(keycode), .keycode_aux(keycode_aux), .atBounds(atBounds),
    .charIsMoving(charIsMoving), .charIsRunning(charIsRunning),
    .direction(direction), .charMoveFrame(charMoveFrame),
    .step_pulse(step_pulse), .tile_done(tile_done)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  bit nontick_bad = 1'b0;
  logic [6:0] obs;
  logic [6:0] exp_v;
  logic [6:0] exp_q[$];

  // {moving, frame[1:0], step, done, dir[1:0]}
  function automatic logic [6:0] mk(input logic mov, input logic [1:0] fr,
                                    input logic st, input logic dn, input logic [1:0] dir);
    return {mov, fr, st, dn, dir};
  endfunction

  function automatic logic [6:0] walk(input int m, input int mend, input logic pulses,
                                      input logic [1:0] dir);
    logic fin;
    fin = (m == mend);
    return mk(!fin, fin ? 2'd0 : 2'((m / 8) % 3), pulses && (m % 2 == 0),
              pulses && (m % 32 == 0), dir);
  endfunction

  // One frame tick; outputs sampled on the negedge after the processing edge.
  task automatic tick();
    @(negedge Clk) VGA_VS = 1'b1;
    @(negedge Clk);
    obs = {charIsMoving, charMoveFrame, step_pulse, tile_done, direction};
    VGA_VS = 1'b0;
    @(negedge Clk);
    if (step_pulse || tile_done) nontick_bad = 1'b1;
  endtask

  task automatic test_reset();
    int busy;
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    checks++;
    if ({charIsMoving, charIsRunning, charMoveFrame, step_pulse, tile_done, direction} !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got=%b exp=00000000",
               {charIsMoving, charIsRunning, charMoveFrame, step_pulse, tile_done, direction});
    end
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (obs[6] || obs[3] || obs[2]) busy++;
    end
    checks++;
    if (busy !== 0) begin
      errors++;
      $display("FAIL idle_no_key got=%0d active ticks exp=0", busy);
    end
  endtask

  task automatic test_walk();
    int steps;
    keycode = 8'h16;
    exp_q.push_back(mk(1'b1, 2'd0, 1'b0, 1'b0, 2'd0));
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL walk_start got=%b exp=%b", obs, exp_v); end
    steps = 0;
    for (int m = 1; m <= 64; m++) begin
      if (m == 40) keycode = 8'h00;
      exp_q.push_back(walk(m, 64, 1'b1, 2'd0));
      tick();
      exp_v = exp_q.pop_front();
      if (obs[3]) steps++;
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL walk_m%0d got=%b exp=%b", m, obs, exp_v); end
    end
    checks++;
    if (steps !== 32) begin errors++; $display("FAIL walk_steps got=%0d exp=32", steps); end
  endtask

  task automatic test_turn_run();
    int steps;
    keycode = 8'h07;
    keycode_aux = 8'h2C;
    for (int t = 1; t <= 6; t++) begin
      exp_q.push_back(t <= 4 ? mk(1'b0, 2'd1, 1'b0, 1'b0, 2'd3)
                   : t == 5  ? mk(1'b0, 2'd0, 1'b0, 1'b0, 2'd3)
                             : mk(1'b1, 2'd0, 1'b0, 1'b0, 2'd3));
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL turn_t%0d got=%b exp=%b", t, obs, exp_v); end
    end
    steps = 0;
    for (int m = 1; m <= 16; m++) begin
      if (m == 10) begin keycode = 8'h00; keycode_aux = 8'h00; end
      exp_q.push_back(mk(m < 16, m < 16 ? 2'((m / 8) % 3) : 2'd0, 1'b1, m == 16, 2'd3));
      checks++;
      if (charIsRunning !== 1'b1) begin errors++; $display("FAIL run_flag_m%0d got=%b exp=1", m, charIsRunning); end
      tick();
      exp_v = exp_q.pop_front();
      if (obs[3]) steps++;
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL run_m%0d got=%b exp=%b", m, obs, exp_v); end
    end
    checks++;
    if (steps !== 16) begin errors++; $display("FAIL run_steps got=%0d exp=16", steps); end
  endtask

  task automatic test_release();
    int steps;
    keycode = 8'h07;
    tick();
    checks++;
    if (charIsMoving !== 1'b1 || charIsRunning !== 1'b0) begin
      errors++; $display("FAIL release_start got=%b%b exp=10", charIsMoving, charIsRunning);
    end
    steps = 0;
    for (int m = 1; m <= 32; m++) begin
      if (m == 5) keycode = 8'h00;
      exp_q.push_back(walk(m, 32, 1'b1, 2'd3));
      tick();
      exp_v = exp_q.pop_front();
      if (obs[3]) steps++;
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL release_m%0d got=%b exp=%b", m, obs, exp_v); end
    end
    checks++;
    if (steps !== 16) begin errors++; $display("FAIL release_steps got=%0d exp=16", steps); end
  endtask

  task automatic test_bounds_end();
    keycode = 8'h07;
    tick();
    for (int m = 1; m <= 32; m++) begin
      if (m == 31) atBounds = 1'b1;
      exp_q.push_back(walk(m, 32, 1'b1, 2'd3));
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL bend_m%0d got=%b exp=%b", m, obs, exp_v); end
    end
`ifdef CHAR_MOTION_BUMP_EN
    keycode = 8'h00;
`endif
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 2'd3));
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL bend_after%0d got=%b exp=%b", i, obs, exp_v); end
    end
  endtask

  task automatic test_bounds_idle();
    keycode = 8'h07;
    atBounds = 1'b1;
    for (int m = 0; m <= 32; m++) begin
`ifdef CHAR_MOTION_BUMP_EN
      exp_q.push_back(m == 0 ? mk(1'b1, 2'd0, 1'b0, 1'b0, 2'd3) : walk(m, 32, 1'b0, 2'd3));
`else
      exp_q.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 2'd3));
`endif
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL bidle_m%0d got=%b exp=%b", m, obs, exp_v); end
    end
    keycode = 8'h00;
    atBounds = 1'b0;
  endtask

  task automatic test_ingame();
    keycode = 8'h07;
    repeat (6) tick();
    @(negedge Clk) in_game = 1'b0;
    @(negedge Clk);
    exp_q.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 2'd3));
    exp_v = exp_q.pop_front();
    obs = {charIsMoving, charMoveFrame, step_pulse, tile_done, direction};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ingame_clear got=%b exp=%b", obs, exp_v); end
    exp_q.push_back(mk(1'b0, 2'd0, 1'b0, 1'b0, 2'd3));
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ingame_hold got=%b exp=%b", obs, exp_v); end
    in_game = 1'b1;
    for (int m = 0; m <= 2; m++) begin
      exp_q.push_back(m == 0 ? mk(1'b1, 2'd0, 1'b0, 1'b0, 2'd3) : walk(m, 32, 1'b1, 2'd3));
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL ingame_restart%0d got=%b exp=%b", m, obs, exp_v); end
    end
    keycode = 8'h00;
    repeat (30) tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] all;
    keycode = 8'h07;
    repeat (10) tick();
    @(negedge Clk);
    VGA_VS = 1'b1;
    Reset = 1'b0;
    exp_q.push_back('0);
    @(negedge Clk);
    all = {charIsMoving, charIsRunning, charMoveFrame, step_pulse, tile_done, direction};
    exp_v = exp_q.pop_front();
    checks++;
    if (all !== {1'b0, exp_v}) begin errors++; $display("FAIL reset_mid got=%b exp=00000000", all); end
    Reset = 1'b1;
    VGA_VS = 1'b0;
    keycode = 8'h00;
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    test_reset();
    test_walk();
    test_turn_run();
    test_release();
    test_bounds_end();
    test_bounds_idle();
    test_ingame();
    test_reset_mid();
    checks++;
    if (nontick_bad !== 1'b0) begin errors++; $display("FAIL nontick_pulse got=1 exp=0"); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
